// File: rtl/module_regbank_spi_arb_pkg.sv
// Shared types and helpers for the host/SPI arbitrated register bank.
package pkg_spi_regbank;

  // Bank ownership: host port or SPI engine port.
  typedef enum logic [0:0] {
    ST_HOST = 1'b0,
    ST_SPI  = 1'b1
  } state_e;

  // Address width for a bank of 'depth' words (at least one bit).
  function automatic int unsigned aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/module_regbank_spi_arb_burst_ptr.sv
// SPI burst pointer: start load, per-access increment with wrap, length count and done pulse.
module module_spi_burst_ptr
  import pkg_spi_regbank::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = aw(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          active_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   len_i,
  input  logic          access_i,
  output logic [AW-1:0] ptr_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_inc;
  logic          done_q;

  assign cnt_inc = (AW + 1)'(cnt_q + 1'b1);

  // Pointer/counter update; losing ownership aborts the burst count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_i) begin
        cnt_q <= '0;
      end else if (start_i) begin
        ptr_q <= base_i;
        cnt_q <= '0;
      end else if (access_i) begin
        ptr_q <= (ptr_q == LAST) ? '0 : AW'(ptr_q + 1'b1);
        if ((len_i != '0) && (cnt_inc == len_i)) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign ptr_o  = ptr_q;
  assign done_o = done_q;

endmodule

// File: rtl/module_regbank_spi_arb.sv
// Register bank shared between a host port and an SPI engine, with ownership
// handshake, byte-enabled host writes, burst pointer and per-entry dirty flags.
module module_regbank_spi_arb
  import pkg_spi_regbank::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned AW     = aw(DEPTH),
  localparam int unsigned NB     = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              hold_ctrl_i,
  output logic              hold_ack_o,
  input  logic              host_we_i,
  input  logic              host_re_i,
  input  logic [AW-1:0]     host_addr_i,
  input  logic [NB-1:0]     host_be_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  output logic              host_busy_o,
  input  logic              spi_start_i,
  input  logic [AW-1:0]     spi_base_i,
  input  logic [AW:0]       spi_len_i,
  input  logic              spi_we_i,
  input  logic              spi_re_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic [DATA_W-1:0] spi_rdata_o,
  output logic              spi_rvalid_o,
  output logic              spi_done_o,
  output logic [DEPTH-1:0]  dirty_o
);

  // One bit per encodable address; set where the address maps to a real word.
  localparam int unsigned          NSLOT   = 1 << AW;
  localparam logic [NSLOT-1:0]     ADDR_OK = NSLOT'((64'd1 << DEPTH) - 64'd1);

  state_e              state_q, state_d;
  logic                hold_ack_q, host_busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    dirty_q;
  logic [DATA_W-1:0]   host_rdata_q, spi_rdata_q;
  logic                host_rvalid_q, spi_rvalid_q;
  logic [AW-1:0]       spi_ptr;
  logic                host_own, spi_own;
  logic                host_wr, host_rd, spi_wr, spi_rd, spi_acc;
  logic                host_ok, spi_ok;

  // Ownership state register and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_HOST;
      hold_ack_q  <= 1'b0;
      host_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_ack_q  <= (state_d == ST_SPI);
      host_busy_q <= (state_d == ST_SPI);
    end
  end

  // Next ownership state follows the SPI hold request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOST: if (hold_ctrl_i)  state_d = ST_SPI;
      ST_SPI:  if (!hold_ctrl_i) state_d = ST_HOST;
      default: state_d = ST_HOST;
    endcase
  end

  // Strobe qualification: each port acts only while it owns the bank.
  assign host_own = (state_q == ST_HOST);
  assign spi_own  = (state_q == ST_SPI);
  assign host_wr  = host_own & host_we_i;
  assign host_rd  = host_own & host_re_i;
  assign spi_acc  = spi_own & ~spi_start_i & (spi_we_i | spi_re_i);
  assign spi_wr   = spi_acc & spi_we_i;
  assign spi_rd   = spi_acc & spi_re_i;
  assign host_ok  = ADDR_OK[host_addr_i];
  assign spi_ok   = ADDR_OK[spi_ptr];

  module_spi_burst_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_burst_ptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .active_i (spi_own),
    .start_i  (spi_start_i),
    .base_i   (spi_base_i),
    .len_i    (spi_len_i),
    .access_i (spi_acc),
    .ptr_o    (spi_ptr),
    .done_o   (spi_done_o)
  );

  // Storage and dirty flags; ownership makes host and SPI updates exclusive.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      if (host_wr && host_ok) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (host_be_i[b]) mem_q[host_addr_i][b*8 +: 8] <= host_wdata_i[b*8 +: 8];
        end
      end
      if (spi_wr && spi_ok) begin
        mem_q[spi_ptr]   <= spi_wdata_i;
        dirty_q[spi_ptr] <= 1'b1;
      end
      if ((host_wr || host_rd) && host_ok) dirty_q[host_addr_i] <= 1'b0;
    end
  end

  // Registered reads: sample pre-write contents, out-of-range reads return zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      spi_rdata_q   <= '0;
      spi_rvalid_q  <= 1'b0;
    end else begin
      host_rvalid_q <= host_rd;
      spi_rvalid_q  <= spi_rd;
      if (host_rd) host_rdata_q <= host_ok ? mem_q[host_addr_i] : '0;
      if (spi_rd)  spi_rdata_q  <= spi_ok ? mem_q[spi_ptr] : '0;
    end
  end

  assign hold_ack_o    = hold_ack_q;
  assign host_busy_o   = host_busy_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign spi_rdata_o   = spi_rdata_q;
  assign spi_rvalid_o  = spi_rvalid_q;
  assign dirty_o       = dirty_q;

endmodule

// File: tb/tb_module_regbank_spi_arb.sv
// Self-checking bench for module_regbank_spi_arb: host vector table plus SPI sequences,
// read data checked through per-port expected-value queues.
module tb_module_regbank_spi_arb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic              clk_i;
  logic              reset_i;
  logic              hold_ctrl_i;
  logic              hold_ack_o;
  logic              host_we_i;
  logic              host_re_i;
  logic [AW-1:0]     host_addr_i;
  logic [3:0]        host_be_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic [DATA_W-1:0] host_rdata_o;
  logic              host_rvalid_o;
  logic              host_busy_o;
  logic              spi_start_i;
  logic [AW-1:0]     spi_base_i;
  logic [AW:0]       spi_len_i;
  logic              spi_we_i;
  logic              spi_re_i;
  logic [DATA_W-1:0] spi_wdata_i;
  logic [DATA_W-1:0] spi_rdata_o;
  logic              spi_rvalid_o;
  logic              spi_done_o;
  logic [DEPTH-1:0]  dirty_o;

  module_regbank_spi_arb #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .hold_ctrl_i   (hold_ctrl_i),
    .hold_ack_o    (hold_ack_o),
    .host_we_i     (host_we_i),
    .host_re_i     (host_re_i),
    .host_addr_i   (host_addr_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rdata_o  (host_rdata_o),
    .host_rvalid_o (host_rvalid_o),
    .host_busy_o   (host_busy_o),
    .spi_start_i   (spi_start_i),
    .spi_base_i    (spi_base_i),
    .spi_len_i     (spi_len_i),
    .spi_we_i      (spi_we_i),
    .spi_re_i      (spi_re_i),
    .spi_wdata_i   (spi_wdata_i),
    .spi_rdata_o   (spi_rdata_o),
    .spi_rvalid_o  (spi_rvalid_o),
    .spi_done_o    (spi_done_o),
    .dirty_o       (dirty_o)
  );

  initial clk_i = 1'b0;
  always #50 clk_i = ~clk_i;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  int dc_before  = 0;

  logic [31:0] host_q[$];
  logic [31:0] spi_q[$];

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk_i);
    #10;
  endtask

  task automatic clear_strobes();
    host_we_i   = 1'b0;
    host_re_i   = 1'b0;
    spi_start_i = 1'b0;
    spi_we_i    = 1'b0;
    spi_re_i    = 1'b0;
  endtask

  task automatic host_op(input logic we, input logic re, input logic [2:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp, input logic push);
    host_we_i    = we;
    host_re_i    = re;
    host_addr_i  = addr;
    host_be_i    = be;
    host_wdata_i = wd;
    if (re && push) host_q.push_back(exp);
    step();
    clear_strobes();
  endtask

  task automatic spi_begin(input logic [2:0] base, input logic [3:0] len);
    spi_base_i  = base;
    spi_len_i   = len;
    spi_start_i = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic spi_acc(input logic we, input logic re, input logic [31:0] wd,
                         input logic [31:0] exp, input logic push);
    spi_we_i    = we;
    spi_re_i    = re;
    spi_wdata_i = wd;
    if (re && push) spi_q.push_back(exp);
    step();
    clear_strobes();
  endtask

  // Scoreboard: every read-valid pulse must match the oldest expected value.
  always @(negedge clk_i) begin
    if (host_rvalid_o) begin
      if (host_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL host_rvalid_unexpected actual=1 required=0");
      end else begin
        chk("host_rdata", host_rdata_o, host_q.pop_front());
      end
    end
    if (spi_rvalid_o) begin
      if (spi_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spi_rvalid_unexpected actual=1 required=0");
      end else begin
        chk("spi_rdata", spi_rdata_o, spi_q.pop_front());
      end
    end
    if (spi_done_o) done_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd3, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'd3, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 4'h5, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 4'h0, 32'h0,        32'hDE22BE44};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 4'h2, 32'hCAFEF00D, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 4'h0, 32'h0,        32'h0000F000};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd7, 4'h8, 32'h12345678, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'd7, 4'h0, 32'h0,        32'h12000000};
    vecs[9]  = '{1'b1, 1'b1, 3'd3, 4'hF, 32'h55555555, 32'hDE22BE44};
    vecs[10] = '{1'b0, 1'b1, 3'd3, 4'h0, 32'h0,        32'h55555555};

    reset_i      = 1'b1;
    hold_ctrl_i  = 1'b0;
    host_addr_i  = '0;
    host_be_i    = '0;
    host_wdata_i = '0;
    spi_base_i   = '0;
    spi_len_i    = '0;
    spi_wdata_i  = '0;
    clear_strobes();
    repeat (3) step();
    reset_i = 1'b0;
    step();

    // Reset state
    chk("rst_hold_ack", 32'(hold_ack_o), 32'd0);
    chk("rst_busy", 32'(host_busy_o), 32'd0);
    chk("rst_dirty", 32'(dirty_o), 32'd0);
    chk("rst_host_rdata", host_rdata_o, 32'd0);
    chk("rst_spi_rdata", spi_rdata_o, 32'd0);
    chk("rst_valids_done", 32'({host_rvalid_o, spi_rvalid_o, spi_done_o}), 32'd0);

    // Host port vector table
    for (int i = 0; i < 11; i++) begin
      host_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, 1'b1);
    end
    step();

    // SPI strobes while the host owns the bank are ignored
    spi_acc(1'b1, 1'b1, 32'hBADBAD00, 32'h0, 1'b0);
    step();
    host_op(1'b0, 1'b1, 3'd0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Take ownership, wrapping burst 6,7,0,1
    hold_ctrl_i = 1'b1;
    step();
    chk("spi_hold_ack", 32'(hold_ack_o), 32'd1);
    chk("spi_busy", 32'(host_busy_o), 32'd1);
    spi_begin(3'd6, 4'd4);
    for (int i = 0; i < 4; i++) begin
      spi_acc(1'b1, 1'b0, 32'(32'hA0 + i), 32'h0, 1'b0);
      if (i < 3) chk("done_early", 32'(spi_done_o), 32'd0);
    end
    chk("done_pulse", 32'(spi_done_o), 32'd1);
    step();
    chk("done_single", 32'(spi_done_o), 32'd0);
    chk("done_count_burst", 32'(done_count), 32'd1);
    chk("dirty_burst", 32'(dirty_o), 32'h000000C3);

    // Host write dropped while SPI owns the bank
    host_op(1'b1, 1'b0, 3'd0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
    chk("busy_during_spi", 32'(host_busy_o), 32'd1);
    hold_ctrl_i = 1'b0;
    step();
    chk("release_hold_ack", 32'(hold_ack_o), 32'd0);
    chk("release_busy", 32'(host_busy_o), 32'd0);
    host_op(1'b0, 1'b1, 3'd0, 4'h0, 32'h0, 32'h000000A2, 1'b1);
    chk("dirty_after_read0", 32'(dirty_o), 32'h000000C2);
    host_op(1'b0, 1'b1, 3'd1, 4'h0, 32'h0, 32'h000000A3, 1'b1);
    chk("dirty_after_read1", 32'(dirty_o), 32'h000000C0);

    // Aborted burst produces no done pulse
    hold_ctrl_i = 1'b1;
    step();
    spi_begin(3'd0, 4'd5);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h000000A2, 1'b1);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h000000A3, 1'b1);
    dc_before   = done_count;
    hold_ctrl_i = 1'b0;
    repeat (3) step();
    chk("abort_no_done", 32'(done_count - dc_before), 32'd0);
    hold_ctrl_i = 1'b1;
    step();
    spi_begin(3'd4, 4'd1);
    spi_acc(1'b1, 1'b0, 32'h00000077, 32'h0, 1'b0);
    chk("len1_done", 32'(spi_done_o), 32'd1);

    // Same-cycle write and read at pointer 2 returns old data and advances
    spi_begin(3'd2, 4'd0);
    spi_acc(1'b1, 1'b0, 32'h00000005, 32'h0, 1'b0);
    spi_begin(3'd2, 4'd0);
    spi_acc(1'b1, 1'b1, 32'h00000009, 32'h00000005, 1'b1);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h55555555, 1'b1);
    spi_begin(3'd2, 4'd0);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h00000009, 1'b1);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h55555555, 1'b1);
    spi_begin(3'd4, 4'd0);
    spi_acc(1'b0, 1'b1, 32'h0, 32'h00000077, 1'b1);

    // Reset in the middle of a burst, with a write on the reset edge
    spi_begin(3'd1, 4'd3);
    spi_acc(1'b1, 1'b0, 32'h000000BB, 32'h0, 1'b0);
    step();
    reset_i     = 1'b1;
    hold_ctrl_i = 1'b0;
    spi_we_i    = 1'b1;
    spi_wdata_i = 32'h000000CC;
    step();
    reset_i = 1'b0;
    clear_strobes();
    chk("midrst_hold_ack", 32'(hold_ack_o), 32'd0);
    chk("midrst_dirty", 32'(dirty_o), 32'd0);
    chk("midrst_spi_rdata", spi_rdata_o, 32'd0);
    chk("midrst_host_rdata", host_rdata_o, 32'd0);
    chk("midrst_done", 32'(spi_done_o), 32'd0);
    host_op(1'b0, 1'b1, 3'd1, 4'h0, 32'h0, 32'h0, 1'b1);
    host_op(1'b0, 1'b1, 3'd2, 4'h0, 32'h0, 32'h0, 1'b1);
    host_op(1'b0, 1'b1, 3'd3, 4'h0, 32'h0, 32'h0, 1'b1);
    repeat (3) step();

    chk("host_q_drained", 32'(host_q.size()), 32'd0);
    chk("spi_q_drained", 32'(spi_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
